// File: rtl/cuppa_trigger_multi.sv
// N-channel ADC trigger: delayed stream pass-through, masked threshold discriminators with
// M-of-N coincidence, fixed-priority EXT/THRESH/SW arbitration, holdoff and trigger counting.
module cuppa_trigger_multi #(
  parameter int N_CHAN     = 4,
  parameter int ADC_W      = 12,
  parameter int STREAM_DLY = 1,
  parameter int HOLDOFF_W  = 16,
  parameter int CNT_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CHAN*ADC_W-1:0]        adc_stream_in,
  output logic [N_CHAN*ADC_W-1:0]        adc_stream_out,
  input  logic                           gt,
  input  logic                           et,
  input  logic                           lt,
  input  logic [ADC_W-1:0]               thr,
  input  logic [N_CHAN-1:0]              chan_en,
  input  logic                           thresh_trig_en,
  input  logic [$clog2(N_CHAN+1)-1:0]    min_coinc,
  input  logic [HOLDOFF_W-1:0]           holdoff,
  input  logic                           run,
  input  logic                           ext_trig_en,
  input  logic                           ext_run,
  output logic                           trig,
  output logic [1:0]                     trig_src,
  output logic [N_CHAN-1:0]              thresh_tot,
  output logic                           busy,
  output logic [CNT_W-1:0]               trig_count
);

  // state   | meaning
  // IDLE    | accepting trigger requests
  // HOLD    | dead time after a trigger, requests discarded
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [1:0] TRIG_SRC_NONE   = 2'd0;
  localparam logic [1:0] TRIG_SRC_SW     = 2'd1;
  localparam logic [1:0] TRIG_SRC_THRESH = 2'd2;
  localparam logic [1:0] TRIG_SRC_EXT    = 2'd3;

  localparam int CW = $clog2(N_CHAN+1);

  logic                    i_rst;
  logic [N_CHAN*ADC_W-1:0] dly [STREAM_DLY];
  logic [N_CHAN-1:0]       act;
  logic [N_CHAN-1:0]       masked;
  logic [CW-1:0]           nact;
  logic [CW-1:0]           min_eff;
  logic                    thr_hit;
  logic                    run_q, ext_run_q;
  logic                    run_p, ext_run_p;
  logic [1:0]              req_src;
  logic [0:0]              state;
  logic [HOLDOFF_W-1:0]    hold_cnt;

  always_ff @(posedge clk) begin
    i_rst <= rst;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < STREAM_DLY; i++) dly[i] <= '0;
    end else begin
      dly[0] <= adc_stream_in;
      for (int i = 1; i < STREAM_DLY; i++) dly[i] <= dly[i-1];
    end
  end

  assign adc_stream_out = dly[STREAM_DLY-1];

  for (genvar k = 0; k < N_CHAN; k++) begin : g_disc
    logic [ADC_W-1:0] samp;
    assign samp   = adc_stream_in[k*ADC_W +: ADC_W];
    assign act[k] = (gt & (samp > thr)) | (et & (samp == thr)) | (lt & (samp < thr));
  end

  assign masked = act & chan_en;

  always_comb begin
    nact = '0;
    for (int k = 0; k < N_CHAN; k++) nact = nact + CW'(masked[k]);
  end

  // A zero coincidence setting behaves as one so an idle bus never self-triggers.
  assign min_eff   = (min_coinc == '0) ? CW'(1) : min_coinc;
  assign thr_hit   = thresh_trig_en & (nact >= min_eff);
  assign run_p     = run & ~run_q;
  assign ext_run_p = ext_trig_en & ext_run & ~ext_run_q;

  always_comb begin
    req_src = TRIG_SRC_NONE;
    if (ext_run_p)    req_src = TRIG_SRC_EXT;
    else if (thr_hit) req_src = TRIG_SRC_THRESH;
    else if (run_p)   req_src = TRIG_SRC_SW;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      run_q      <= 1'b0;
      ext_run_q  <= 1'b0;
      thresh_tot <= '0;
      trig       <= 1'b0;
      trig_src   <= TRIG_SRC_NONE;
      busy       <= 1'b0;
      trig_count <= '0;
      state      <= ST_IDLE;
      hold_cnt   <= '0;
    end else begin
      run_q      <= run;
      ext_run_q  <= ext_run;
      thresh_tot <= masked;
      // busy trails the state by one cycle so it covers exactly the dead cycles after trig
      busy       <= (state == ST_HOLD);
      trig       <= 1'b0;
      trig_src   <= TRIG_SRC_NONE;
      case (state)
        ST_IDLE: begin
          if (req_src != TRIG_SRC_NONE) begin
            trig       <= 1'b1;
            trig_src   <= req_src;
            trig_count <= trig_count + 1'b1;
            if (holdoff != '0) begin
              hold_cnt <= holdoff;
              state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLDOFF_W'(1)) state <= ST_IDLE;
          else hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cuppa_trigger_multi.sv
// Directed bench for cuppa_trigger_multi (4 channels, 3-cycle stream delay, 4-bit counter).
module tb_cuppa_trigger_multi;
  localparam int N  = 4;
  localparam int W  = 12;
  localparam int D  = 3;
  localparam int HW = 16;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  adc_in;
  logic [N*W-1:0]  adc_out;
  logic            gt, et, lt;
  logic [W-1:0]    thr;
  logic [N-1:0]    chan_en;
  logic            thresh_trig_en;
  logic [2:0]      min_coinc;
  logic [HW-1:0]   holdoff;
  logic            run, ext_trig_en, ext_run;
  logic            trig;
  logic [1:0]      trig_src;
  logic [N-1:0]    thresh_tot;
  logic            busy;
  logic [CW-1:0]   trig_count;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_cnt;

  cuppa_trigger_multi #(
    .N_CHAN(N), .ADC_W(W), .STREAM_DLY(D), .HOLDOFF_W(HW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .adc_stream_in(adc_in), .adc_stream_out(adc_out),
    .gt(gt), .et(et), .lt(lt), .thr(thr), .chan_en(chan_en),
    .thresh_trig_en(thresh_trig_en), .min_coinc(min_coinc), .holdoff(holdoff),
    .run(run), .ext_trig_en(ext_trig_en), .ext_run(ext_run),
    .trig(trig), .trig_src(trig_src), .thresh_tot(thresh_tot), .busy(busy),
    .trig_count(trig_count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [W-1:0] v);
    adc_in[k*W +: W] = v;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_ch(2, 12'd7);
    step;
    step;
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (adc_out !== '0 || trig !== 1'b0 || trig_src !== 2'd0 || thresh_tot !== '0 ||
          busy !== 1'b0 || trig_count !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: out=%h trig=%b src=%0d tot=%b busy=%b cnt=%0d, need all 0",
                 c, adc_out, trig, trig_src, thresh_tot, busy, trig_count);
      end
      step;
    end
    exp_cnt = '0;
  endtask

  task automatic test_stream;
    logic [W-1:0] hist [10];
    for (int i = 0; i < 10; i++) begin
      hist[i] = W'(10*i + 5);
      set_ch(2, hist[i]);
      step;
      if (i >= D-1) begin
        checks++;
        if (adc_out[2*W +: W] !== hist[i-(D-1)] || adc_out[0 +: W] !== '0) begin
          errors++;
          $display("FAIL stream_delay i=%0d: ch2=%0d ch0=%0d, need ch2=%0d ch0=0",
                   i, adc_out[2*W +: W], adc_out[0 +: W], hist[i-(D-1)]);
        end
      end
    end
    set_ch(2, 12'd0);
    step;
  endtask

  task automatic test_coincidence;
    thr = 12'd100; gt = 1'b1; chan_en = 4'b1011; min_coinc = 3'd2;
    thresh_trig_en = 1'b1; holdoff = '0;
    set_ch(0, 12'd200);
    step;
    checks++;
    if (trig !== 1'b0 || thresh_tot !== 4'b0001) begin
      errors++;
      $display("FAIL coinc_one trig=%b tot=%b, need trig=0 tot=0001", trig, thresh_tot);
    end
    set_ch(1, 12'd200);
    step;
    exp_cnt++;
    checks++;
    if (trig !== 1'b1 || trig_src !== 2'd2 || thresh_tot !== 4'b0011 || trig_count !== exp_cnt) begin
      errors++;
      $display("FAIL coinc_two trig=%b src=%0d tot=%b cnt=%0d, need 1/2/0011/%0d",
               trig, trig_src, thresh_tot, trig_count, exp_cnt);
    end
    set_ch(1, 12'd0); set_ch(2, 12'd200);
    step;
    checks++;
    if (trig !== 1'b0 || trig_src !== 2'd0 || thresh_tot !== 4'b0001) begin
      errors++;
      $display("FAIL coinc_masked trig=%b src=%0d tot=%b, need 0/0/0001", trig, trig_src, thresh_tot);
    end
    set_ch(0, 12'd0); set_ch(2, 12'd0);
    step;
  endtask

  task automatic test_bounds;
    chan_en = 4'b1111;
    for (int k = 0; k < N; k++) set_ch(k, 12'd200);
    min_coinc = 3'd5;
    step;
    checks++;
    if (trig !== 1'b0 || thresh_tot !== 4'b1111) begin
      errors++;
      $display("FAIL coinc_above_n trig=%b tot=%b, need 0/1111", trig, thresh_tot);
    end
    min_coinc = 3'd4;
    step;
    exp_cnt++;
    checks++;
    if (trig !== 1'b1 || trig_src !== 2'd2) begin
      errors++;
      $display("FAIL coinc_all_n trig=%b src=%0d, need 1/2", trig, trig_src);
    end
    for (int k = 0; k < N; k++) set_ch(k, 12'd0);
    min_coinc = 3'd0;
    step;
    checks++;
    if (trig !== 1'b0) begin
      errors++;
      $display("FAIL coinc_zero_idle trig=%b, need 0", trig);
    end
    gt = 1'b0; et = 1'b1;
    set_ch(3, 12'd100);
    step;
    exp_cnt++;
    checks++;
    if (trig !== 1'b1 || thresh_tot !== 4'b1000) begin
      errors++;
      $display("FAIL mode_et_min0 trig=%b tot=%b, need 1/1000", trig, thresh_tot);
    end
    et = 1'b0; lt = 1'b1;
    set_ch(3, 12'd0);
    set_ch(0, 12'd100); set_ch(1, 12'd100); set_ch(2, 12'd100);
    step;
    exp_cnt++;
    checks++;
    if (thresh_tot !== 4'b1000 || trig_count !== exp_cnt) begin
      errors++;
      $display("FAIL mode_lt tot=%b cnt=%0d, need 1000/%0d", thresh_tot, trig_count, exp_cnt);
    end
    lt = 1'b0; gt = 1'b1; chan_en = 4'b1011; min_coinc = 3'd2;
    for (int k = 0; k < N; k++) set_ch(k, 12'd0);
    step;
  endtask

  task automatic test_holdoff;
    holdoff = 16'd5;
    set_ch(0, 12'd200); set_ch(1, 12'd200);
    for (int j = 0; j < 14; j++) begin
      step;
      if (j % 6 == 0) exp_cnt++;
      checks++;
      if (trig !== (j % 6 == 0) || busy !== (j % 6 != 0) || trig_count !== exp_cnt) begin
        errors++;
        $display("FAIL holdoff5 t+%0d: trig=%b busy=%b cnt=%0d, need %b/%b/%0d",
                 j, trig, busy, trig_count, (j % 6 == 0), (j % 6 != 0), exp_cnt);
      end
    end
    set_ch(0, 12'd0); set_ch(1, 12'd0);
    repeat (6) step;
    holdoff = 16'd0;
    set_ch(0, 12'd200); set_ch(1, 12'd200);
    for (int j = 0; j < 4; j++) begin
      step;
      exp_cnt++;
      checks++;
      if (trig !== 1'b1 || busy !== 1'b0 || trig_count !== exp_cnt) begin
        errors++;
        $display("FAIL holdoff0 j=%0d: trig=%b busy=%b cnt=%0d, need 1/0/%0d",
                 j, trig, busy, trig_count, exp_cnt);
      end
    end
    set_ch(0, 12'd0); set_ch(1, 12'd0);
    step;
  endtask

  task automatic test_priority;
    ext_trig_en = 1'b1; run = 1'b0; ext_run = 1'b0;
    step;
    run = 1'b1; ext_run = 1'b1; set_ch(0, 12'd200); set_ch(1, 12'd200);
    step;
    exp_cnt++;
    checks++;
    if (trig !== 1'b1 || trig_src !== 2'd3 || trig_count !== exp_cnt) begin
      errors++;
      $display("FAIL prio_ext trig=%b src=%0d cnt=%0d, need 1/3/%0d", trig, trig_src, trig_count, exp_cnt);
    end
    step;
    exp_cnt++;
    checks++;
    if (trig !== 1'b1 || trig_src !== 2'd2) begin
      errors++;
      $display("FAIL prio_level_held trig=%b src=%0d, need 1/2", trig, trig_src);
    end
    set_ch(0, 12'd0); set_ch(1, 12'd0);
    step;
    checks++;
    if (trig !== 1'b0 || trig_src !== 2'd0) begin
      errors++;
      $display("FAIL prio_no_edge trig=%b src=%0d, need 0/0", trig, trig_src);
    end
    ext_trig_en = 1'b0; run = 1'b0; ext_run = 1'b0;
    step;
    run = 1'b1; ext_run = 1'b1; set_ch(0, 12'd200); set_ch(1, 12'd200);
    step;
    exp_cnt++;
    checks++;
    if (trig !== 1'b1 || trig_src !== 2'd2 || trig_count !== exp_cnt) begin
      errors++;
      $display("FAIL prio_ext_off trig=%b src=%0d cnt=%0d, need 1/2/%0d", trig, trig_src, trig_count, exp_cnt);
    end
    set_ch(0, 12'd0); set_ch(1, 12'd0); run = 1'b0; ext_run = 1'b0;
    step;
    step;
  endtask

  task automatic test_dropped;
    holdoff = 16'd4;
    run = 1'b1;
    step;
    exp_cnt++;
    checks++;
    if (trig !== 1'b1 || trig_src !== 2'd1) begin
      errors++;
      $display("FAIL drop_first trig=%b src=%0d, need 1/1", trig, trig_src);
    end
    run = 1'b0;
    step;
    checks++;
    if (trig !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_busy trig=%b busy=%b, need 0/1", trig, busy);
    end
    run = 1'b1;
    for (int j = 2; j <= 8; j++) begin
      step;
      checks++;
      if (trig !== 1'b0) begin
        errors++;
        $display("FAIL drop_discard j=%0d trig=%b, need 0", j, trig);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle busy=%b, need 0", busy);
    end
    run = 1'b0;
    step;
    run = 1'b1;
    step;
    exp_cnt++;
    checks++;
    if (trig !== 1'b1 || trig_src !== 2'd1 || trig_count !== exp_cnt) begin
      errors++;
      $display("FAIL drop_second trig=%b src=%0d cnt=%0d, need 1/1/%0d", trig, trig_src, trig_count, exp_cnt);
    end
    run = 1'b0;
    repeat (6) step;
  endtask

  task automatic test_reset_mid_hold;
    holdoff = 16'd20;
    run = 1'b1;
    step;
    run = 1'b0;
    step;
    step;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midhold_busy busy=%b, need 1", busy);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    step;
    exp_cnt = '0;
    checks++;
    if (busy !== 1'b0 || trig_count !== 4'd0 || trig !== 1'b0) begin
      errors++;
      $display("FAIL midhold_reset busy=%b cnt=%0d trig=%b, need 0/0/0", busy, trig_count, trig);
    end
    step;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midhold_after busy=%b, need 0", busy);
    end
  endtask

  task automatic test_wrap;
    logic [CW-1:0] zero_cnt;
    zero_cnt = '0;
    holdoff = 16'd0;
    set_ch(0, 12'd200); set_ch(1, 12'd200);
    for (int i = 0; i < 16; i++) begin
      step;
      exp_cnt++;
      checks++;
      if (trig !== 1'b1 || trig_count !== exp_cnt) begin
        errors++;
        $display("FAIL wrap i=%0d trig=%b cnt=%0d, need 1/%0d", i, trig, trig_count, exp_cnt);
      end
    end
    checks++;
    if (trig_count !== zero_cnt) begin
      errors++;
      $display("FAIL wrap_zero cnt=%0d, need 0", trig_count);
    end
    set_ch(0, 12'd0); set_ch(1, 12'd0);
    step;
  endtask

  initial begin
    rst = 1'b0; adc_in = '0; gt = 1'b0; et = 1'b0; lt = 1'b0; thr = '0;
    chan_en = '0; thresh_trig_en = 1'b0; min_coinc = '0; holdoff = '0;
    run = 1'b0; ext_trig_en = 1'b0; ext_run = 1'b0; exp_cnt = '0;
    test_reset;
    test_stream;
    test_coincidence;
    test_bounds;
    test_holdoff;
    test_priority;
    test_dropped;
    test_reset_mid_hold;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cuppa_trigger_multi.md
Name: cuppa_trigger_multi

Overview:
N-channel, width-parametrised successor to the two-channel zedboard trigger.
- Passes ADC streams through a configurable delay line.
- Forms per-channel threshold discriminators with channel masking and an M-of-N coincidence requirement.
- Arbitrates external, threshold and software triggers by fixed priority.
- Enforces a programmable holdoff (dead time) after every trigger and counts issued triggers.
- Sits between the ADC capture front end and the waveform buffer/readout logic.

Parameters:
N_CHAN, 4, number of ADC channels (≥1)
ADC_W, 12, sample width in bits
STREAM_DLY, 1, pipeline delay of adc_stream_out relative to adc_stream_in, in cycles (≥1)
HOLDOFF_W, 16, width of holdoff setting/counter
CNT_W, 32, width of trigger counter

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
adc_stream_in  in  N_CHAN*ADC_W  packed samples, channel k at bits [k*ADC_W +: ADC_W]
adc_stream_out  out  N_CHAN*ADC_W  delayed samples, same packing
gt  in  1  threshold compare mode: sample > thr
et  in  1  threshold compare mode: sample == thr
lt  in  1  threshold compare mode: sample < thr
thr  in  ADC_W  common threshold, unsigned
chan_en  in  N_CHAN  per-channel discriminator enable
thresh_trig_en  in  1  enable threshold triggering
min_coinc  in  clog2(N_CHAN+1)  required number of simultaneously active channels
holdoff  in  HOLDOFF_W  dead cycles after each trigger
run  in  1  software trigger level; rising edge requests a trigger
ext_trig_en  in  1  enable external trigger
ext_run  in  1  external trigger level; rising edge requests a trigger
trig  out  1  one-cycle trigger pulse
trig_src  out  2  source of current trig: 0 none, 1 SW, 2 THRESH, 3 EXT (shared TRIG_SRC_* constants)
thresh_tot  out  N_CHAN  registered, masked per-channel discriminator state
busy  out  1  high while in holdoff
trig_count  out  CNT_W  number of triggers issued since reset

Behaviour:
- Reset handling
  - rst is registered once internally (i_rst); all state clears on the cycle after rst is sampled high.
  - Reset values: adc_stream_out=0, delay line=0, thresh_tot=0, trig=0, trig_src=0, busy=0, trig_count=0, FSM=IDLE, edge-detector history=0.
- Stream path
  - STREAM_DLY-deep shift register per channel; output equals input from STREAM_DLY cycles earlier.
- Discriminator
  - Combinational per channel: a = (gt & s>thr) | (et & s==thr) | (lt & s<thr), unsigned.
  - Masked by chan_en.
  - thresh_tot registers the masked vector with 1-cycle latency.
- Coincidence
  - nact = popcount(masked vector), computed on the same cycle as the compare.
  - thr_hit = thresh_trig_en & (nact ≥ max(min_coinc,1)).
  - min_coinc > N_CHAN never hits.
- Edge detect
  - run_p / ext_run_p are one-cycle pulses on 0→1 transitions of run / ext_run.
  - Edge-detector history registers update every cycle, including during holdoff.
- Arbitration (registered, 1-cycle latency)
  - Priority: ext_trig_en & ext_run_p → EXT; else thr_hit → THRESH; else run_p → SW.
  - trig_src is nonzero only while trig=1.
- FSM
  - IDLE: a qualifying request sets trig=1 and trig_src for one cycle. If holdoff≠0, load counter=holdoff and go to HOLD; if holdoff=0, stay IDLE, so a request on every cycle gives trig every cycle.
  - HOLD: busy=1; requests are discarded, not queued. The counter decrements each cycle; on reaching 1, return to IDLE. Exactly holdoff cycles without trig follow each trig.
  - The holdoff value is sampled only at trigger time; changing it mid-HOLD has no effect until the next trigger.
- Counter
  - trig_count increments on every trig; wraps from 2^CNT_W-1 to 0.
- Simultaneous events
  - One trigger per cycle max; the highest-priority source wins and lower sources for that cycle are dropped.
- Reset mid-HOLD
  - Abort holdoff; return to IDLE with busy=0.
- Configuration changes
  - gt/et/lt/thr/chan_en changes take effect on the next compared sample, without glitching the registered outputs.

Test Plan:
- Reset/pass-through: N_CHAN=4, STREAM_DLY=3, ramp on ch2 → adc_stream_out ch2 equals input 3 cycles earlier; all outputs 0 for the two cycles after rst.
- Coincidence: thr=100, gt=1, chan_en=4'b1011, min_coinc=2, ch0=200, others 0 → no trig. Set ch1=200 → trig, src=2, thresh_tot=4'b0011. ch2=200 alone with ch0 → no trig (masked).
- Holdoff: holdoff=5, sustained threshold hit → trig at cycles t, t+6, t+12; busy high during cycles t+1..t+5. holdoff=0 → trig on every cycle.
- Priority: ext_run rise, thr_hit and run rise on the same cycle with ext_trig_en=1 → single trig, src=3, trig_count+1. With ext_trig_en=0 → src=2.
- Dropped requests: run rises during HOLD → no trig after holdoff expires; a second rise after IDLE → trig, src=1.
- Reset mid-HOLD and counter wrap: rst during HOLD → busy=0 the cycle after i_rst. CNT_W=4, 16 triggers → trig_count returns to 0.
